slc3_mem_arbiter: RTL

Shares the single SLC-3 SRAM between two requesters: the CPU memory interface and a loader/debug port used to preload programs. Sequences each SRAM access with a fixed number of wait cycles and drives the active-low SRAM controls. Decodes one memory-mapped I/O word at IO_ADDR: reads return the board switches; writes update the hex-display register. Sits between the SLC-3 datapath/ISDU and the SRAM pins, under the top-level test_slc3 wrapper.

---
 rtl/slc3_mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/slc3_mem_arbiter.sv
// Two-port (CPU / loader) arbiter for the single SLC-3 SRAM, with one MMIO word for switches/hex.
// Optional macro ARB_RR_EN selects round-robin arbitration; otherwise the loader has fixed priority.
module slc3_mem_arbiter #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic [15:0] ldr_rdata,
    output logic        ldr_ack,
    input  logic [15:0] S,
    output logic [15:0] hex_data,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        CE,
    output logic        OE,
    output logic        WE,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        grant_reg;            // 1 = loader, 0 = CPU
    logic        we_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] sram_addr_reg;
    logic [15:0] sram_wdata_reg;
    logic [15:0] hex_reg;

    logic        any_req, win, sel_we, is_io, granted_req;
    logic [15:0] sel_addr, sel_wdata;
    logic        grant_now, load_io_rd, load_sram_rd;

    assign any_req = cpu_req | ldr_req;

`ifdef ARB_RR_EN
    // Pointer names the port that wins the next tie; it flips away from each winner.
    logic ptr_reg;
    assign win = (cpu_req & ldr_req) ? ptr_reg : ldr_req;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            ptr_reg <= 1'b1;
        else if (grant_now)
            ptr_reg <= ~win;
    end
`else
    assign win = ldr_req;
`endif

    assign sel_we      = win ? ldr_we    : cpu_we;
    assign sel_addr    = win ? ldr_addr  : cpu_addr;
    assign sel_wdata   = win ? ldr_wdata : cpu_wdata;
    assign is_io       = (sel_addr == IO_ADDR);
    assign granted_req = grant_reg ? ldr_req : cpu_req;

    assign grant_now    = (state_reg == IDLE) && any_req;
    assign load_io_rd   = grant_now && is_io && !sel_we;
    assign load_sram_rd = (state_reg == ACCESS) && (cnt_reg == 4'd0) && !we_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = is_io ? DONE : ACCESS;
            ACCESS:  if (cnt_reg == 4'd0) state_next = DONE;
            DONE:    if (!granted_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SRAM address/data registers only change on SRAM grants, so they hold through DONE and MMIO.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            grant_reg      <= 1'b0;
            we_reg         <= 1'b0;
            cnt_reg        <= 4'd0;
            sram_addr_reg  <= 16'h0000;
            sram_wdata_reg <= 16'h0000;
            hex_reg        <= 16'h0000;
        end else if (grant_now) begin
            grant_reg <= win;
            we_reg    <= sel_we;
            if (is_io) begin
                if (sel_we)
                    hex_reg <= sel_wdata;
            end else begin
                sram_addr_reg <= sel_addr;
                cnt_reg       <= CNT_INIT;
                if (sel_we)
                    sram_wdata_reg <= sel_wdata;
            end
        end else if (state_reg == ACCESS && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            logic [15:0] rdata_reg;
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset)
                    rdata_reg <= 16'h0000;
                else if (load_io_rd && win == 1'(gi))
                    rdata_reg <= S;
                else if (load_sram_rd && grant_reg == 1'(gi))
                    rdata_reg <= Data_from_SRAM;
            end
        end
    endgenerate

    assign cpu_rdata = g_rdata[0].rdata_reg;
    assign ldr_rdata = g_rdata[1].rdata_reg;

    // Controls decode straight from state so an async reset releases them immediately.
    always_comb begin
        CE      = 1'b1;
        OE      = 1'b1;
        WE      = 1'b1;
        cpu_ack = 1'b0;
        ldr_ack = 1'b0;
        if (state_reg == ACCESS) begin
            CE = 1'b0;
            OE = we_reg;
            WE = ~we_reg;
        end
        if (state_reg == DONE) begin
            cpu_ack = ~grant_reg;
            ldr_ack = grant_reg;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign ADDR         = {4'h0, sram_addr_reg};
    assign Data_to_SRAM = sram_wdata_reg;
    assign hex_data     = hex_reg;

endmodule
